// File: rtl/tb_data_router_pkg.sv
// rtl/tb_data_router_pkg.sv - shared types and address defaults for the data router
package tb_data_router_pkg;

    // Target index field width; wide enough for up to 256 targets
    localparam int ROUTER_IDX_W = 8;

    localparam logic [31:0] EXIT_ADDR_DEFAULT = 32'h80000000;
    localparam logic [31:0] PUTC_ADDR_DEFAULT = 32'h80000004;

    // One in-flight transaction: which target answers, or an internal answer
    typedef struct packed {
        logic [ROUTER_IDX_W-1:0] idx;
        logic                    err;
        logic                    mbox;
    } router_entry_t;

endpackage

// File: rtl/tb_router_fifo.sv
// rtl/tb_router_fifo.sv - generic in-order tracking FIFO with head output
module tb_router_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push+pop together keeps count steady
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observed while the FIFO is non-empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tb_data_router.sv
// rtl/tb_data_router.sv - core-to-targets router with tracked responses (option: TB_DATA_ROUTER_MAILBOX_EN)
module tb_data_router
    import tb_data_router_pkg::*;
#(
    parameter int                   NT              = 3,
    parameter int                   MAX_OUTSTANDING = 4,
    parameter logic [NT-1:0][31:0]  REGION_BASE     = {NT{32'h0}},
    parameter logic [NT-1:0][31:0]  REGION_MASK     = {NT{32'hFF000000}},
    parameter logic [31:0]          EXIT_ADDR       = EXIT_ADDR_DEFAULT,
    parameter logic [31:0]          PUTC_ADDR       = PUTC_ADDR_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 data_req_i,
    output logic                 data_gnt_o,
    input  logic                 data_we_i,
    input  logic [3:0]           data_be_i,
    input  logic [31:0]          data_addr_i,
    input  logic [31:0]          data_wdata_i,
    output logic                 data_rvalid_o,
    output logic [31:0]          data_rdata_o,
    output logic                 data_err_o,
    output logic [NT-1:0]        tgt_req_o,
    output logic [NT-1:0][31:0]  tgt_add_o,
    output logic [NT-1:0]        tgt_wen_o,
    output logic [NT-1:0][3:0]   tgt_be_o,
    output logic [NT-1:0][31:0]  tgt_data_o,
    input  logic [NT-1:0]        tgt_gnt_i,
    input  logic [NT-1:0][31:0]  tgt_r_data_i,
    input  logic [NT-1:0]        tgt_r_valid_i,
    output logic                 exit_valid_o,
    output logic [31:0]          exit_code_o
);

    logic                    hit;
    logic [ROUTER_IDX_W-1:0] sel;
    logic                    sel_gnt;
    logic                    mbox_hit;
    logic                    full;
    logic                    empty;
    logic                    pop;
    router_entry_t           push_entry;
    router_entry_t           head;

    // Region decode; scanning downwards lets the lowest matching index win
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NT - 1; i >= 0; i--) begin
            if ((data_addr_i & REGION_MASK[i]) == REGION_BASE[i]) begin
                hit = 1'b1;
                sel = ROUTER_IDX_W'(i);
            end
        end
    end

`ifdef TB_DATA_ROUTER_MAILBOX_EN
    assign mbox_hit = data_we_i && ((data_addr_i == EXIT_ADDR) || (data_addr_i == PUTC_ADDR));

    // Exit code capture; valid stays set until reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exit_valid_o <= 1'b0;
            exit_code_o  <= '0;
        end else if (data_gnt_o && mbox_hit && (data_addr_i == EXIT_ADDR)) begin
            exit_valid_o <= 1'b1;
            exit_code_o  <= data_wdata_i;
        end
    end

`ifndef SYNTHESIS
    // Character output from the simulated program
    always @(posedge clk_i) begin
        if (rst_ni && data_gnt_o && mbox_hit && (data_addr_i == PUTC_ADDR))
            $write("%c", data_wdata_i[7:0]);
    end
`endif
`else
    logic unused_mbox_addr;
    assign unused_mbox_addr = ^{EXIT_ADDR, PUTC_ADDR};
    assign mbox_hit         = 1'b0;
    assign exit_valid_o     = 1'b0;
    assign exit_code_o      = '0;
`endif

    // Issue side: one target request, grant from that target or internal grant
    always_comb begin
        tgt_req_o = '0;
        sel_gnt   = 1'b0;
        for (int i = 0; i < NT; i++) begin
            if (sel == ROUTER_IDX_W'(i)) begin
                sel_gnt      = tgt_gnt_i[i];
                tgt_req_o[i] = data_req_i & hit & ~mbox_hit & ~full;
            end
        end
        data_gnt_o      = data_req_i & ~full & (mbox_hit | ~hit | sel_gnt);
        push_entry.idx  = sel;
        push_entry.err  = ~hit & ~mbox_hit;
        push_entry.mbox = mbox_hit;
    end

    // Address, byte enables and write data are broadcast to every target
    always_comb begin
        for (int i = 0; i < NT; i++) begin
            tgt_add_o[i]  = data_addr_i & ~REGION_MASK[i];
            tgt_wen_o[i]  = ~data_we_i;
            tgt_be_o[i]   = data_be_i;
            tgt_data_o[i] = data_wdata_i;
        end
    end

    // Response side: only the head target may answer; internal entries answer at once
    always_comb begin
        data_rvalid_o = 1'b0;
        data_rdata_o  = '0;
        data_err_o    = 1'b0;
        if (!empty) begin
            if (head.err || head.mbox) begin
                data_rvalid_o = 1'b1;
                data_err_o    = head.err;
            end else begin
                for (int i = 0; i < NT; i++) begin
                    if (head.idx == ROUTER_IDX_W'(i) && tgt_r_valid_i[i]) begin
                        data_rvalid_o = 1'b1;
                        data_rdata_o  = tgt_r_data_i[i];
                    end
                end
            end
        end
        pop = data_rvalid_o;
    end

`ifndef SYNTHESIS
    // Flag any response that does not belong to the head transaction
    always @(posedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < NT; i++) begin
                if (tgt_r_valid_i[i] &&
                    (empty || head.err || head.mbox || head.idx != ROUTER_IDX_W'(i)))
                    $warning("tb_data_router: stray response from target %0d ignored", i);
            end
        end
    end
`endif

    tb_router_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (router_entry_t)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (data_gnt_o),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

endmodule
